// File: rtl/rpsc_fault_latch_bank.sv
// rpsc_fault_latch_bank
// ---------------------
// N-channel fault/interlock latch card. Every raw fault input passes through a
// 2-flop synchroniser and a symmetric debounce filter, then drives a per-channel
// CLEAR/LATCHED alarm latch. The card also keeps the first channel to latch and
// counts trip events with a saturating counter.
//
// Ports
//   clk                in   system clock
//   reset              in   asynchronous, active-high reset
//   fault_in[N_CH]     in   raw fault inputs (asynchronous, active-high)
//   fault_mask[N_CH]   in   1 = channel may not latch (an existing latch is kept)
//   ack                in   operator latch reset; level-sampled on every edge
//   fault_out[N_CH]    out  debounced, unlatched fault status
//   fault_la[N_CH]     out  latched alarm per channel (the latch state itself)
//   trip               out  OR of fault_la, purely combinational
//   first_fault_valid  out  first_fault_id holds a valid channel index
//   first_fault_id     out  lowest channel of the group that latched first
//   trip_count         out  number of trip 0->1 events, saturating
module rpsc_fault_latch_bank #(
  parameter int N_CH            = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TRIP_CNT_W      = 8,
  localparam int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       fault_in,
  input  logic [N_CH-1:0]       fault_mask,
  input  logic                  ack,
  output logic [N_CH-1:0]       fault_out,
  output logic [N_CH-1:0]       fault_la,
  output logic                  trip,
  output logic                  first_fault_valid,
  output logic [ID_W-1:0]       first_fault_id,
  output logic [TRIP_CNT_W-1:0] trip_count
);

  typedef enum logic {
    LATCH_CLEAR = 1'b0,
    LATCH_SET   = 1'b1
  } latch_state_e;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TRIP_CNT_W-1:0] TRIP_MAX = {TRIP_CNT_W{1'b1}};

  logic [N_CH-1:0]       sync1_q, sync2_q;
  logic [N_CH-1:0]       fout_q, fout_d;
  logic [CNT_W-1:0]      cnt_q [N_CH];
  logic [CNT_W-1:0]      cnt_d [N_CH];
  latch_state_e          latch_q [N_CH];
  latch_state_e          latch_d [N_CH];
  logic [N_CH-1:0]       la_cur, la_next;
  logic                  ffv_q, ffv_d;
  logic [ID_W-1:0]       ffid_q, ffid_d;
  logic [ID_W-1:0]       low_id;
  logic [TRIP_CNT_W-1:0] tcnt_q, tcnt_d;

  always_comb begin
    fout_d  = fout_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    la_cur  = '0;
    la_next = '0;
    low_id  = '0;
    ffv_d   = ffv_q;
    ffid_d  = ffid_q;
    tcnt_d  = tcnt_q;

    for (int i = 0; i < N_CH; i++) begin
      // Debounce: count consecutive samples that disagree with the filtered
      // state; the DEBOUNCE_CYCLES-th disagreeing sample flips it.
      if (sync2_q[i] != fout_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          fout_d[i] = ~fout_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end

      // Latch: uses the registered debounced value, so fault_la trails
      // fault_out by one clock. Set wins over an ack on the same edge.
      case (latch_q[i])
        LATCH_CLEAR: if (fout_q[i] && !fault_mask[i]) latch_d[i] = LATCH_SET;
        LATCH_SET: begin
          if (!(fout_q[i] && !fault_mask[i]) && ack && !fout_q[i])
            latch_d[i] = LATCH_CLEAR;
        end
        default: latch_d[i] = LATCH_CLEAR;
      endcase

      la_cur[i]  = (latch_q[i] == LATCH_SET);
      la_next[i] = (latch_d[i] == LATCH_SET);
    end

    // Scan downwards so the lowest latching index is the one left standing.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (la_next[i]) low_id = ID_W'(i);
    end

    // With nothing latched now, every bit of la_next is a newly latching channel.
    if (la_cur == '0 && la_next != '0) begin
      ffv_d  = 1'b1;
      ffid_d = low_id;
      if (tcnt_q != TRIP_MAX) tcnt_d = tcnt_q + TRIP_CNT_W'(1);
    end else if (la_next == '0) begin
      ffv_d  = 1'b0;
      ffid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      fout_q  <= '0;
      ffv_q   <= 1'b0;
      ffid_q  <= '0;
      tcnt_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= '0;
        latch_q[i] <= LATCH_CLEAR;
      end
    end else begin
      sync1_q <= fault_in;
      sync2_q <= sync1_q;
      fout_q  <= fout_d;
      ffv_q   <= ffv_d;
      ffid_q  <= ffid_d;
      tcnt_q  <= tcnt_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        latch_q[i] <= latch_d[i];
      end
    end
  end

  assign fault_out         = fout_q;
  assign fault_la          = la_cur;
  assign trip              = |la_cur;
  assign first_fault_valid = ffv_q;
  assign first_fault_id    = ffid_q;
  assign trip_count        = tcnt_q;

endmodule

// File: tb/tb_rpsc_fault_latch_bank.sv
module tb_rpsc_fault_latch_bank;

  localparam int N  = 8;
  localparam int D  = 16;
  localparam int TW = 2;
  localparam int IW = 3;
  localparam int TC_MAX = (1 << TW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  fault_in, fault_mask;
  logic          ack;
  logic [N-1:0]  fault_out, fault_la;
  logic          trip, first_fault_valid;
  logic [IW-1:0] first_fault_id;
  logic [TW-1:0] trip_count;

  always #5 clk = ~clk;

  rpsc_fault_latch_bank #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .TRIP_CNT_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .fault_in(fault_in), .fault_mask(fault_mask),
    .ack(ack), .fault_out(fault_out), .fault_la(fault_la), .trip(trip),
    .first_fault_valid(first_fault_valid), .first_fault_id(first_fault_id),
    .trip_count(trip_count)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [N-1:0]  fo;
    logic [N-1:0]  la;
    logic          trip;
    logic          ffv;
    logic [IW-1:0] ffid;
    logic [TW-1:0] tc;
  } exp_t;

  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  int checks   = 0;
  int failures = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Behavioural card: inputs seen two edges late, a run length of disagreeing
  // samples per channel, and the latch / first-fault / counter rules.
  bit [N-1:0] m_seen1, m_seen2, m_out, m_la;
  int         m_run [N];
  bit         m_ffv;
  int         m_ffid, m_tc;

  function automatic void model_reset();
    m_seen1 = '0; m_seen2 = '0; m_out = '0; m_la = '0;
    m_ffv = 1'b0; m_ffid = 0; m_tc = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endfunction

  function automatic void model_edge(bit rst, bit [N-1:0] fi, bit [N-1:0] mk, bit a);
    bit [N-1:0] new_out;
    bit [N-1:0] new_la;
    if (rst) begin
      model_reset();
      return;
    end
    new_out = m_out;
    for (int i = 0; i < N; i++) begin
      if (m_seen2[i] != m_out[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          new_out[i] = !m_out[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      new_la[i] = (m_out[i] && !mk[i]) || (m_la[i] && !(a && !m_out[i]));
    end
    if (m_la == 0 && new_la != 0) begin
      m_ffv = 1'b1;
      for (int i = N - 1; i >= 0; i--) if (new_la[i]) m_ffid = i;
      if (m_tc < TC_MAX) m_tc = m_tc + 1;
    end else if (new_la == 0) begin
      m_ffv  = 1'b0;
      m_ffid = 0;
    end
    m_seen2 = m_seen1;
    m_seen1 = fi;
    m_out   = new_out;
    m_la    = new_la;
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.fo   = m_out;
    e.la   = m_la;
    e.trip = |m_la;
    e.ffv  = m_ffv;
    e.ffid = IW'(m_ffid);
    e.tc   = TW'(m_tc);
    exp_q.push_back(e);
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; the model then advances
  // one edge per step.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge(reset, fault_in, fault_mask, ack);
    push_expected();
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_fault_out", 32'(fault_out), 32'(e.fo));
        check("mon_fault_la", 32'(fault_la), 32'(e.la));
        check("mon_trip", 32'(trip), 32'(e.trip));
        check("mon_ff_valid", 32'(first_fault_valid), 32'(e.ffv));
        check("mon_ff_id", 32'(first_fault_id), 32'(e.ffid));
        check("mon_trip_count", 32'(trip_count), 32'(e.tc));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bit found;

    reset = 1'b1; fault_in = '0; fault_mask = '0; ack = 1'b0;
    model_reset();
    steps(3);
    reset = 1'b0;

    // Idle after reset.
    steps(50);
    check("idle_fault_out", 32'(fault_out), 0);
    check("idle_fault_la", 32'(fault_la), 0);
    check("idle_trip", 32'(trip), 0);
    check("idle_trip_count", 32'(trip_count), 0);
    check("idle_ff_valid", 32'(first_fault_valid), 0);

    // Short glitch is filtered.
    fault_in[3] = 1'b1; steps(10);
    fault_in[3] = 1'b0; steps(30);
    check("glitch_fault_out", 32'(fault_out), 0);
    check("glitch_fault_la", 32'(fault_la), 0);
    check("glitch_trip", 32'(trip), 0);

    // Rising-edge latency, then latch one clock later.
    fault_in[3] = 1'b1; lat = 0; found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      step();
      if (fault_out[3]) begin found = 1'b1; lat = k; end
    end
    check("rise_latency", 32'(lat), 18);
    check("la_before_latch", 32'(fault_la[3]), 0);
    step();
    check("la3_set", 32'(fault_la[3]), 1);
    check("trip_set", 32'(trip), 1);
    check("ff_id_3", 32'(first_fault_id), 3);
    check("ff_valid_3", 32'(first_fault_valid), 1);
    check("trip_count_1", 32'(trip_count), 1);

    // Ack while still faulted keeps the latch.
    ack_pulse();
    check("ack_while_fault", 32'(fault_la[3]), 1);

    // Falling-edge latency is symmetric.
    fault_in[3] = 1'b0; lat = 0; found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      step();
      if (!fault_out[3]) begin found = 1'b1; lat = k; end
    end
    check("fall_latency", 32'(lat), 18);
    ack_pulse();
    check("clear_la", 32'(fault_la), 0);
    check("clear_ff_valid", 32'(first_fault_valid), 0);

    // Simultaneous faults: lowest index wins.
    fault_in[5] = 1'b1; fault_in[2] = 1'b1;
    steps(18);
    check("sim_la_pre", 32'(fault_la), 0);
    step();
    check("sim_la", 32'(fault_la), 32'h24);
    check("sim_ff_id", 32'(first_fault_id), 2);
    check("sim_trip_count", 32'(trip_count), 2);
    fault_in[0] = 1'b1;
    steps(19);
    check("add0_la", 32'(fault_la), 32'h25);
    check("add0_ff_id", 32'(first_fault_id), 2);
    check("add0_trip_count", 32'(trip_count), 2);

    // Partial ack clears only the channel whose fault has gone.
    fault_in[5] = 1'b0; steps(20);
    ack_pulse();
    check("partial_la", 32'(fault_la), 32'h05);
    check("partial_ff_valid", 32'(first_fault_valid), 1);
    check("partial_ff_id", 32'(first_fault_id), 2);
    fault_in = '0; steps(20);
    ack_pulse();
    check("final_la", 32'(fault_la), 0);
    check("final_trip", 32'(trip), 0);
    check("final_ff_valid", 32'(first_fault_valid), 0);
    check("final_ff_id", 32'(first_fault_id), 0);

    // Masking blocks latching only.
    fault_mask[4] = 1'b1; fault_in[4] = 1'b1;
    steps(22);
    check("mask_fault_out", 32'(fault_out[4]), 1);
    check("mask_fault_la", 32'(fault_la[4]), 0);
    fault_mask[4] = 1'b0;
    step();
    check("unmask_la", 32'(fault_la[4]), 1);
    fault_mask[4] = 1'b1;
    step();
    check("mask_keeps_latch", 32'(fault_la[4]), 1);
    fault_in = '0; steps(20);
    ack_pulse();
    check("masked_ack_clear", 32'(fault_la[4]), 0);
    fault_mask = '0;

    // Counter saturation.
    for (int r = 0; r < 3; r++) begin
      fault_in[6] = 1'b1; steps(20);
      fault_in[6] = 1'b0; steps(20);
      ack_pulse();
    end
    check("trip_count_sat", 32'(trip_count), TC_MAX);

    // Randomised traffic including held ack.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 23) == 0) fault_in[i] = !fault_in[i];
      if ($urandom_range(0, 49) == 0) fault_mask = N'($urandom_range(0, 255)) & N'($urandom_range(0, 255));
      if (c >= 1200) ack = 1'b1;
      else ack = ($urandom_range(0, 7) == 0);
      step();
    end
    ack = 1'b0; fault_mask = '0; fault_in = '0;
    steps(20);
    ack_pulse();

    // Async reset in the middle of a debounce.
    fault_in[1] = 1'b1; fault_in[6] = 1'b1;
    steps(21);
    fault_in[6] = 1'b0;
    fault_in[1] = 1'b0; steps(2);
    fault_in[1] = 1'b1; steps(10);
    #3;
    reset = 1'b1;
    #1;
    check("async_fault_out", 32'(fault_out), 0);
    check("async_fault_la", 32'(fault_la), 0);
    check("async_trip", 32'(trip), 0);
    check("async_ff_valid", 32'(first_fault_valid), 0);
    check("async_ff_id", 32'(first_fault_id), 0);
    check("async_trip_count", 32'(trip_count), 0);
    model_reset();
    steps(2);
    reset = 1'b0;
    steps(30);
    check("post_reset_la1", 32'(fault_la[1]), 1);

    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
